// File: rtl/slave_port.sv
// Serial slave port: 3-cycle start, serial header, bit-serial write/read
// Ports: clk, rstN (sync, high), control/wrD/valid/last in; rD/ready out
module slave_port #(
  parameter int         ADDRESS_DEPTH = 12,
  parameter int         DATA_WIDTH    = 16,
  parameter logic [1:0] SLAVE_ID      = 2'b00,
  parameter int         MEM_DEPTH     = 4096
) (
  input  logic clk,
  input  logic rstN,
  input  logic control,
  input  logic wrD,
  input  logic valid,
  input  logic last,
  output logic rD,
  output logic ready
);

  localparam int AW  = ADDRESS_DEPTH;
  localparam int DW  = DATA_WIDTH;
  localparam int HW  = AW + 4;
  localparam int HCW = $clog2(HW + 1);
  localparam int BCW = $clog2(DW + 1);

  typedef enum logic [2:0] {
    IDLE, HEADER, WRITE, RDFETCH, READ
  } state_t;

  state_t state, state_n;

  logic [1:0]    scnt;
  logic [HCW-1:0] hcnt;
  logic [HW-2:0] hsh;
  logic [HW-1:0] hfull;
  logic [BCW-1:0] bcnt;
  logic [AW-1:0] addr;
  logic [AW-1:0] addr_inc;
  logic [AW-1:0] hdr_addr;
  logic          burst;
  logic          lseen;
  logic [DW-2:0] wsh;
  logic [DW-1:0] rsh;
  logic          wr_pend;
  logic [DW-1:0] wr_word;
  logic [AW-1:0] wr_addr;

  logic [DW-1:0] mem [MEM_DEPTH];

  logic start, hdone, hit;
  logic wbit, wdone, wend;
  logic rbit, rdone, rend;

  always_comb begin
    hfull    = {hsh, control};
    hdr_addr = AW'(32'(hfull[AW-1:0]) % 32'(MEM_DEPTH));
    addr_inc = (32'(addr) == 32'(MEM_DEPTH - 1))
             ? '0 : addr + AW'(1);
    start = (state == IDLE) && control
         && (scnt == 2'd2);
    hdone = (state == HEADER)
         && (hcnt == HCW'(HW - 1));
    hit   = (hfull[HW-1 -: 2] == SLAVE_ID);
    wbit  = (state == WRITE) && valid;
    wdone = wbit && (bcnt == BCW'(DW - 1));
    wend  = wdone && (!burst || last);
    rbit  = (state == READ) && valid && ready;
    rdone = rbit && (bcnt == BCW'(DW - 1));
    // last may arrive on any accepted bit of the word
    rend  = rdone && (!burst || last || lseen);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = HEADER;
      HEADER:
        if (hdone) begin
          if (!hit)
            state_n = IDLE;
          else if (hfull[HW-3])
            state_n = WRITE;
          else
            state_n = RDFETCH;
        end
      WRITE:   if (wend) state_n = IDLE;
      RDFETCH: state_n = READ;
      READ:
        if (rend)
          state_n = IDLE;
        else if (rdone)
          state_n = RDFETCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstN) begin
      state   <= IDLE;
      ready   <= 1'b0;
      scnt    <= '0;
      hcnt    <= '0;
      hsh     <= '0;
      bcnt    <= '0;
      addr    <= '0;
      burst   <= 1'b0;
      lseen   <= 1'b0;
      wsh     <= '0;
      rsh     <= '0;
      wr_pend <= 1'b0;
      wr_word <= '0;
      wr_addr <= '0;
    end else begin
      state <= state_n;
      ready <= (state_n == WRITE)
            || (state_n == READ);

      if (state != IDLE || start || !control)
        scnt <= '0;
      else
        scnt <= scnt + 2'd1;

      if (state == HEADER) begin
        hcnt <= hcnt + HCW'(1);
        hsh  <= hfull[HW-2:0];
      end else begin
        hcnt <= '0;
        hsh  <= '0;
      end

      if (hdone) begin
        addr  <= hdr_addr;
        burst <= hfull[HW-4];
      end else if ((wdone && !wend)
                || (rdone && !rend)) begin
        addr <= addr_inc;
      end

      if (wdone || rdone)
        bcnt <= '0;
      else if (wbit || rbit)
        bcnt <= bcnt + BCW'(1);
      else if (state != WRITE
            && state != READ)
        bcnt <= '0;

      if (wbit)
        wsh <= {wsh[DW-3:0], wrD};

      // word lands in memory on the edge after its last bit
      wr_pend <= wdone;
      if (wdone) begin
        wr_word <= {wsh, wrD};
        wr_addr <= addr;
      end

      if (state != READ || rdone)
        lseen <= 1'b0;
      else if (rbit && last)
        lseen <= 1'b1;

      if (state == RDFETCH)
        rsh <= mem[addr];
      else if (rbit)
        rsh <= {rsh[DW-2:0], 1'b0};
    end
  end

  // storage has no reset so contents survive rstN
  always_ff @(posedge clk) begin
    if (wr_pend)
      mem[wr_addr] <= wr_word;
  end

  assign rD = (state == READ) & rsh[DW-1];

endmodule
